// File: rtl/channel_framer_pkg.sv
// Shared defaults, FSM state encodings and the width helper for the channel framer slice.
package channel_framer_pkg;

  localparam int DEFAULT_CHANNEL_WIDTH  = 8;
  localparam int DEFAULT_INPUT_CHANNELS = 32;
  localparam int DEFAULT_FIFO_DEPTH     = 2;

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] COLLECT = 1'b1;

  // Ceiling log2, floored at 1 so single-entry counters/pointers still have a bit.
  function automatic int ceil_log2(input int value);
    int result;
    result = 1;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/framer_fifo.sv
// Small circular-buffer FIFO; head is zero while empty, push is accepted when full if a pop coincides.
module framer_fifo
  import channel_framer_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  localparam int CNT_W = ceil_log2(DEPTH + 1),
  localparam int PTR_W = ceil_log2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             pop_eff;
  logic             push_eff;

  assign empty     = (count_reg == '0);
  assign full      = (count_reg == CNT_W'(DEPTH));
  assign count     = count_reg;
  assign pop_eff   = pop && !empty;
  assign push_eff  = push && (!full || pop_eff);
  assign head_data = empty ? '0 : mem[rd_ptr_reg];

  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (push_eff) mem[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_eff) wr_ptr_reg <= wrap_inc(wr_ptr_reg);
      if (pop_eff)  rd_ptr_reg <= wrap_inc(rd_ptr_reg);
      case ({push_eff, pop_eff})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/channel_framer.sv
// Assembles INPUT_CHANNELS samples into a frame and queues it for the spatial encoder.
// Define CHANNEL_FRAMER_STATS_EN to add saturating drop/error counters.
module channel_framer
  import channel_framer_pkg::*;
#(
  parameter int CHANNEL_WIDTH  = DEFAULT_CHANNEL_WIDTH,
  parameter int INPUT_CHANNELS = DEFAULT_INPUT_CHANNELS,
  parameter int FIFO_DEPTH     = DEFAULT_FIFO_DEPTH,
  localparam int FRAME_WIDTH   = CHANNEL_WIDTH * INPUT_CHANNELS
) (
  input  logic                     Clk_CI,
  input  logic                     Reset_RI,
  input  logic                     SampleValid_SI,
  input  logic                     FrameStart_SI,
  input  logic [CHANNEL_WIDTH-1:0] Sample_DI,
  output logic                     ValidOut_SO,
  input  logic                     ReadyIn_SI,
  output logic [0:FRAME_WIDTH-1]   Raw_DO,
  output logic                     Overflow_SO,
  output logic                     FrameErr_SO
`ifdef CHANNEL_FRAMER_STATS_EN
  ,
  output logic [15:0]              DropCount_DO,
  output logic [15:0]              ErrCount_DO
`endif
);

  localparam int CNT_W  = ceil_log2(INPUT_CHANNELS);
  localparam int FCNT_W = ceil_log2(FIFO_DEPTH + 1);

  logic [0:0]             state_reg, state_next;
  logic [CNT_W-1:0]       cnt_reg, cnt_next;
  logic [FRAME_WIDTH-1:0] asm_reg, asm_next;
  logic [FRAME_WIDTH-1:0] push_frame_reg;
  logic                   push_reg, push_next;
  logic                   frame_err_reg, frame_err_next;
  logic                   overflow_reg, overflow_next;
  logic                   store_en;
  logic [CNT_W-1:0]       store_idx;
  logic                   fifo_full, fifo_empty, fifo_pop;
  logic [FRAME_WIDTH-1:0] fifo_head;
  logic [FCNT_W-1:0]      fifo_count;

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    push_next      = 1'b0;
    frame_err_next = 1'b0;
    store_en       = 1'b0;
    store_idx      = cnt_reg;
    if (SampleValid_SI) begin
      if (FrameStart_SI) begin
        // A start while collecting is a resync: the partial frame is overwritten.
        store_en       = 1'b1;
        store_idx      = '0;
        frame_err_next = (state_reg == COLLECT);
        if (INPUT_CHANNELS == 1) begin
          push_next  = 1'b1;
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          state_next = COLLECT;
          cnt_next   = CNT_W'(1);
        end
      end else if (state_reg == COLLECT) begin
        store_en = 1'b1;
        if (cnt_reg == CNT_W'(INPUT_CHANNELS - 1)) begin
          push_next  = 1'b1;
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
    end
  end

  // Channel 0 sits at the most significant end of the frame.
  for (genvar gi = 0; gi < INPUT_CHANNELS; gi++) begin : g_chan
    localparam int HI = FRAME_WIDTH - 1 - gi * CHANNEL_WIDTH;
    assign asm_next[HI -: CHANNEL_WIDTH] =
      (store_en && store_idx == CNT_W'(gi)) ? Sample_DI : asm_reg[HI -: CHANNEL_WIDTH];
  end

  assign fifo_pop      = !fifo_empty && ReadyIn_SI;
  assign overflow_next = push_reg && fifo_full && !fifo_pop;

  always_ff @(posedge Clk_CI or posedge Reset_RI) begin
    if (Reset_RI) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      asm_reg        <= '0;
      push_reg       <= 1'b0;
      push_frame_reg <= '0;
      frame_err_reg  <= 1'b0;
      overflow_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      asm_reg        <= asm_next;
      push_reg       <= push_next;
      push_frame_reg <= asm_next;
      frame_err_reg  <= frame_err_next;
      overflow_reg   <= overflow_next;
    end
  end

  framer_fifo #(
    .WIDTH (FRAME_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (Clk_CI),
    .rst       (Reset_RI),
    .push      (push_reg),
    .push_data (push_frame_reg),
    .pop       (fifo_pop),
    .head_data (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign ValidOut_SO = !fifo_empty;
  assign Raw_DO      = fifo_head;
  assign Overflow_SO = overflow_reg;
  assign FrameErr_SO = frame_err_reg;

`ifdef CHANNEL_FRAMER_STATS_EN
  logic [15:0] drop_cnt_reg;
  logic [15:0] err_cnt_reg;

  always_ff @(posedge Clk_CI or posedge Reset_RI) begin
    if (Reset_RI) begin
      drop_cnt_reg <= '0;
      err_cnt_reg  <= '0;
    end else begin
      if (overflow_next && drop_cnt_reg != 16'hFFFF) drop_cnt_reg <= drop_cnt_reg + 16'd1;
      if (frame_err_next && err_cnt_reg != 16'hFFFF) err_cnt_reg <= err_cnt_reg + 16'd1;
    end
  end

  assign DropCount_DO = drop_cnt_reg;
  assign ErrCount_DO  = err_cnt_reg;
`endif

endmodule

// File: tb/tb_channel_framer.sv
// Directed bench for channel_framer with 4 channels of 8 bits and a 2-deep FIFO.
module tb_channel_framer;

  logic        clk;
  logic        rst;
  logic        sample_valid;
  logic        frame_start;
  logic [7:0]  sample;
  logic        valid_out;
  logic        ready_in;
  logic [0:31] raw;
  logic        overflow;
  logic        frame_err;
`ifdef CHANNEL_FRAMER_STATS_EN
  logic [15:0] drop_count;
  logic [15:0] err_count;
`endif

  int vectors;
  int miscompares;

  channel_framer #(
    .CHANNEL_WIDTH  (8),
    .INPUT_CHANNELS (4),
    .FIFO_DEPTH     (2)
  ) dut (
    .Clk_CI         (clk),
    .Reset_RI       (rst),
    .SampleValid_SI (sample_valid),
    .FrameStart_SI  (frame_start),
    .Sample_DI      (sample),
    .ValidOut_SO    (valid_out),
    .ReadyIn_SI     (ready_in),
    .Raw_DO         (raw),
    .Overflow_SO    (overflow),
    .FrameErr_SO    (frame_err)
`ifdef CHANNEL_FRAMER_STATS_EN
    ,
    .DropCount_DO   (drop_count),
    .ErrCount_DO    (err_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
    $display("vec %0d %s observed %h expected %h", vectors, tag, observed, expected);
  endtask

  // Apply one input cycle; returns 1 time unit after the sampling edge.
  task automatic drive(input logic v, input logic fs, input logic [7:0] s);
    sample_valid = v;
    frame_start  = fs;
    sample       = s;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    vectors      = 0;
    miscompares  = 0;
    rst          = 1'b1;
    sample_valid = 1'b0;
    frame_start  = 1'b0;
    sample       = 8'h00;
    ready_in     = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", {31'd0, valid_out}, 32'd0);
    check("rst_raw", raw, 32'd0);
    check("rst_ovf", {31'd0, overflow}, 32'd0);
    check("rst_err", {31'd0, frame_err}, 32'd0);
    rst = 1'b0;

    // Basic frame
    drive(1'b1, 1'b1, 8'h11);
    drive(1'b1, 1'b0, 8'h22);
    drive(1'b1, 1'b0, 8'h33);
    drive(1'b1, 1'b0, 8'h44);
    check("basic_not_yet", {31'd0, valid_out}, 32'd0);
    idle();
    check("basic_valid", {31'd0, valid_out}, 32'd1);
    check("basic_raw", raw, 32'h11223344);
    idle();
    check("basic_drained", {31'd0, valid_out}, 32'd0);
    check("basic_raw_zero", raw, 32'd0);

    // Backpressure and overflow: A and B held, C dropped
    ready_in = 1'b0;
    drive(1'b1, 1'b1, 8'hA1); drive(1'b1, 1'b0, 8'hA2); drive(1'b1, 1'b0, 8'hA3); drive(1'b1, 1'b0, 8'hA4);
    drive(1'b1, 1'b1, 8'hB1); drive(1'b1, 1'b0, 8'hB2); drive(1'b1, 1'b0, 8'hB3); drive(1'b1, 1'b0, 8'hB4);
    drive(1'b1, 1'b1, 8'hC1); drive(1'b1, 1'b0, 8'hC2); drive(1'b1, 1'b0, 8'hC3); drive(1'b1, 1'b0, 8'hC4);
    check("bp_head_a", raw, 32'hA1A2A3A4);
    check("bp_ovf_early", {31'd0, overflow}, 32'd0);
    idle();
    check("bp_ovf_pulse", {31'd0, overflow}, 32'd1);
    idle();
    check("bp_ovf_clear", {31'd0, overflow}, 32'd0);
    check("bp_stable_a", raw, 32'hA1A2A3A4);
    ready_in = 1'b1;
    idle();
    check("bp_head_b", raw, 32'hB1B2B3B4);
    idle();
    check("bp_empty", {31'd0, valid_out}, 32'd0);

    // Resync discards the partial frame
    drive(1'b1, 1'b1, 8'hAA);
    drive(1'b1, 1'b0, 8'hBB);
    check("rs_no_err", {31'd0, frame_err}, 32'd0);
    drive(1'b1, 1'b1, 8'h01);
    check("rs_err_pulse", {31'd0, frame_err}, 32'd1);
    drive(1'b1, 1'b0, 8'h02);
    check("rs_err_clear", {31'd0, frame_err}, 32'd0);
    drive(1'b1, 1'b0, 8'h03);
    drive(1'b1, 1'b0, 8'h04);
    idle();
    check("rs_raw", raw, 32'h01020304);
    idle();
    check("rs_single", {31'd0, valid_out}, 32'd0);
`ifdef CHANNEL_FRAMER_STATS_EN
    check("stat_drop", {16'd0, drop_count}, 32'd1);
    check("stat_err", {16'd0, err_count}, 32'd1);
`endif

    // Junk in IDLE, then a frame with gaps
    drive(1'b1, 1'b0, 8'h55);
    drive(1'b1, 1'b0, 8'h66);
    check("junk_no_err", {31'd0, frame_err}, 32'd0);
    check("junk_no_valid", {31'd0, valid_out}, 32'd0);
    drive(1'b1, 1'b1, 8'h10); drive(1'b0, 1'b1, 8'h99);
    drive(1'b1, 1'b0, 8'h20); drive(1'b0, 1'b0, 8'h98);
    drive(1'b1, 1'b0, 8'h30); drive(1'b0, 1'b1, 8'h97);
    drive(1'b1, 1'b0, 8'h40);
    check("gap_no_err", {31'd0, frame_err}, 32'd0);
    idle();
    check("gap_raw", raw, 32'h10203040);
    idle();
    check("gap_drained", {31'd0, valid_out}, 32'd0);

    // Push and pop in the same cycle while full
    ready_in = 1'b0;
    drive(1'b1, 1'b1, 8'hD1); drive(1'b1, 1'b0, 8'hD2); drive(1'b1, 1'b0, 8'hD3); drive(1'b1, 1'b0, 8'hD4);
    drive(1'b1, 1'b1, 8'hE1); drive(1'b1, 1'b0, 8'hE2); drive(1'b1, 1'b0, 8'hE3); drive(1'b1, 1'b0, 8'hE4);
    drive(1'b1, 1'b1, 8'hF1); drive(1'b1, 1'b0, 8'hF2); drive(1'b1, 1'b0, 8'hF3); drive(1'b1, 1'b0, 8'hF4);
    check("pp_head_d", raw, 32'hD1D2D3D4);
    ready_in = 1'b1;
    idle();
    check("pp_no_ovf", {31'd0, overflow}, 32'd0);
    check("pp_head_e", raw, 32'hE1E2E3E4);
    ready_in = 1'b0;
    idle();
    check("pp_no_ovf2", {31'd0, overflow}, 32'd0);
    check("pp_hold_e", raw, 32'hE1E2E3E4);
    ready_in = 1'b1;
    idle();
    check("pp_head_f", raw, 32'hF1F2F3F4);
    idle();
    check("pp_drained", {31'd0, valid_out}, 32'd0);

    // Asynchronous reset mid-frame
    ready_in = 1'b0;
    drive(1'b1, 1'b1, 8'h71); drive(1'b1, 1'b0, 8'h72); drive(1'b1, 1'b0, 8'h73); drive(1'b1, 1'b0, 8'h74);
    idle();
    check("ar_pre_valid", {31'd0, valid_out}, 32'd1);
    drive(1'b1, 1'b1, 8'h81);
    drive(1'b1, 1'b0, 8'h82);
    #2;
    rst = 1'b1;
    #1;
    check("ar_valid_zero", {31'd0, valid_out}, 32'd0);
    check("ar_raw_zero", raw, 32'd0);
`ifdef CHANNEL_FRAMER_STATS_EN
    check("ar_stat_drop", {16'd0, drop_count}, 32'd0);
    check("ar_stat_err", {16'd0, err_count}, 32'd0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
    ready_in = 1'b1;
    drive(1'b1, 1'b0, 8'h55);
    drive(1'b1, 1'b1, 8'h91);
    check("ar_no_err", {31'd0, frame_err}, 32'd0);
    drive(1'b1, 1'b0, 8'h92);
    drive(1'b1, 1'b0, 8'h93);
    drive(1'b1, 1'b0, 8'h94);
    idle();
    check("ar_raw", raw, 32'h91929394);
    idle();
    check("ar_drained", {31'd0, valid_out}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
